// File: rtl/fifo_buffer.sv
// Single-clock FIFO with wrap-bit pointers and a register-array store.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is a registered read.
module fifo_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = 14,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_CNT  = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT  = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // Status is purely a function of the registered pointers.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) && (wr_addr == rd_addr);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_acc      = wr_en & ~full;
        rd_acc      = rd_en & ~empty;
        wr_ptr_d    = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        overflow_d  = wr_en & full;
        underflow_d = rd_en & empty;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data = mem_q[rd_addr];
`else
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule
